// File: rtl/sb_calc_pkg.sv
// Shared definitions for the calculator keypad-to-number path:
// key codes, the converter state enum and width helpers.
package sb_calc_pkg;

    localparam logic [3:0] KEY_POINT = 4'hF;
    localparam logic [3:0] KEY_SIGN  = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_DIVIDE,
        ST_DONE
    } state_t;

    // 10^k, evaluated at elaboration time to build the divisor table.
    function automatic logic [63:0] pow10(input int k);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < k; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // Width needed to hold any mantissa of up to max_digits decimal digits.
    function automatic int calc_acc_w(input int max_digits);
        return $clog2(pow10(max_digits));
    endfunction

    // Dividend width: mantissa pre-shifted by the fraction bits.
    function automatic int calc_div_w(input int max_digits, input int frac_bits);
        return calc_acc_w(max_digits) + frac_bits;
    endfunction

endpackage

// File: rtl/sb_restoring_div.sv
// Restoring unsigned divider, one quotient bit per cycle, fixed DVD_W-cycle run.
// done is high for exactly one cycle after the last iteration; the quotient
// is held until the next load.
module sb_restoring_div
    import sb_calc_pkg::*;
#(
    parameter int DVD_W = 35,
    parameter int DVS_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             abort,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic             done
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [CNT_W-1:0] cnt;
    logic             run;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [DVS_W:0]   rem_sh;
    logic [DVS_W-1:0] rem_sub;
    logic             fits;

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. rem < dvs keeps the difference in range.
    always_comb begin
        rem_sh  = {rem, quotient[DVD_W-1]};
        fits    = (rem_sh >= {1'b0, dvs});
        rem_sub = rem_sh[DVS_W-1:0] - dvs;
    end

    assign done = run && (cnt == '0);

    // Iteration counter (terminal count at zero) and remainder/quotient shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            run      <= 1'b0;
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
        end else if (abort) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt      <= CNT_W'(DVD_W);
            run      <= 1'b1;
            rem      <= '0;
            dvs      <= divisor;
            quotient <= dividend;
        end else if (run) begin
            if (cnt != '0) begin
                cnt      <= cnt - CNT_W'(1);
                rem      <= fits ? rem_sub : rem_sh[DVS_W-1:0];
                quotient <= {quotient[DVD_W-2:0], fits};
            end else begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sb_key2num_conv.sv
// Keypad-to-number converter: collects digit/point/sign/clear keys into a
// decimal mantissa, then divides (mant << FRAC_BITS) by 10^nfrac and applies
// saturation and sign to give a signed fixed-point result.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for start; keys and finish ignored
//   ST_ENTRY  | accepting keys into mant/ndig/nfrac/pt_seen/neg
//   ST_DIVIDE | divider running, keys ignored
//   ST_DONE   | single cycle with result_valid high, then ST_IDLE
module sb_key2num_conv
    import sb_calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FRAC_BITS  = 8,
    parameter int MAX_DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    input  logic             finish,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             ovf,
    output logic             trunc
);

    localparam int ACC_W  = calc_acc_w(MAX_DIGITS);
    localparam int DIV_W  = calc_div_w(MAX_DIGITS, FRAC_BITS);
    localparam int NDIG_W = $clog2(MAX_DIGITS + 1);
    localparam int CMP_W  = (DIV_W > WIDTH) ? DIV_W : WIDTH;
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    state_t            state;
    logic [ACC_W-1:0]  mant;
    logic [NDIG_W-1:0] ndig;
    logic [NDIG_W-1:0] nfrac;
    logic              pt_seen;
    logic              neg;

    logic [ACC_W-1:0]  mant_nxt;
    logic [NDIG_W-1:0] ndig_nxt;
    logic [NDIG_W-1:0] nfrac_nxt;
    logic              pt_nxt;
    logic              neg_nxt;
    logic              trunc_nxt;

    logic [ACC_W-1:0]  pow_tab [MAX_DIGITS+1];
    logic              div_load;
    logic              div_done;
    logic [DIV_W-1:0]  div_q;

    logic [CMP_W-1:0]  q_ext;
    logic              sat;
    logic [WIDTH-1:0]  mag;
    logic [WIDTH-1:0]  res_nxt;

    for (genvar k = 0; k <= MAX_DIGITS; k++) begin : g_pow
        assign pow_tab[k] = ACC_W'(pow10(k));
    end

    // Effect of the key presented this cycle on the entry registers. Used both
    // for normal entry and for a key arriving together with finish, so the
    // divider can be loaded with the post-key mantissa on the same edge.
    always_comb begin
        mant_nxt  = mant;
        ndig_nxt  = ndig;
        nfrac_nxt = nfrac;
        pt_nxt    = pt_seen;
        neg_nxt   = neg;
        trunc_nxt = trunc;
        if (key_valid) begin
            if (key_code <= 4'd9) begin
                if (ndig < NDIG_W'(MAX_DIGITS)) begin
                    mant_nxt = (mant << 3) + (mant << 1) + ACC_W'(key_code);
                    ndig_nxt = ndig + NDIG_W'(1);
                    if (pt_seen) begin
                        nfrac_nxt = nfrac + NDIG_W'(1);
                    end
                end else begin
                    trunc_nxt = 1'b1;
                end
            end else begin
                case (key_code)
                    KEY_POINT: pt_nxt  = 1'b1;
                    KEY_SIGN:  neg_nxt = ~neg;
                    KEY_CLEAR: begin
                        mant_nxt  = '0;
                        ndig_nxt  = '0;
                        nfrac_nxt = '0;
                        pt_nxt    = 1'b0;
                        neg_nxt   = 1'b0;
                        trunc_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign div_load = (state == ST_ENTRY) && finish && !start;

    sb_restoring_div #(
        .DVD_W (DIV_W),
        .DVS_W (ACC_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (div_load),
        .abort    (start),
        .dividend ({mant_nxt, {FRAC_BITS{1'b0}}}),
        .divisor  (pow_tab[nfrac_nxt]),
        .quotient (div_q),
        .done     (div_done)
    );

    // Saturate the unsigned quotient to the largest positive value, then apply
    // the sign; a negative saturated result is therefore -(2^(WIDTH-1)-1).
    always_comb begin
        q_ext   = CMP_W'(div_q);
        sat     = (q_ext > CMP_W'(MAX_POS));
        mag     = sat ? MAX_POS : q_ext[WIDTH-1:0];
        res_nxt = neg ? (~mag + WIDTH'(1)) : mag;
    end

    // Entry FSM with registered outputs; start overrides everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            mant         <= '0;
            ndig         <= '0;
            nfrac        <= '0;
            pt_seen      <= 1'b0;
            neg          <= 1'b0;
            trunc        <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (start) begin
                state   <= ST_ENTRY;
                busy    <= 1'b1;
                mant    <= '0;
                ndig    <= '0;
                nfrac   <= '0;
                pt_seen <= 1'b0;
                neg     <= 1'b0;
                trunc   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_ENTRY: begin
                        mant    <= mant_nxt;
                        ndig    <= ndig_nxt;
                        nfrac   <= nfrac_nxt;
                        pt_seen <= pt_nxt;
                        neg     <= neg_nxt;
                        trunc   <= trunc_nxt;
                        if (finish) begin
                            state <= ST_DIVIDE;
                        end
                    end
                    ST_DIVIDE: begin
                        if (div_done) begin
                            state        <= ST_DONE;
                            result       <= res_nxt;
                            ovf          <= sat;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sb_key2num_conv.sv
// Bench for sb_key2num_conv: directed cases with known fixed-point values plus
// random key streams checked against a decimal-arithmetic reference model.
module tb_sb_key2num_conv;

    localparam int WIDTH      = 32;
    localparam int FRAC_BITS  = 8;
    localparam int MAX_DIGITS = 8;
    localparam int LAT        = 36;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             key_valid;
    logic [3:0]       key_code;
    logic             finish;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             busy;
    logic             ovf;
    logic             trunc;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the operand as the user typed it.
    longint m_mant;
    int     m_ndig;
    int     m_nfrac;
    bit     m_pt;
    bit     m_neg;
    bit     m_trunc;

    always #5 clk = ~clk;

    sb_key2num_conv #(
        .WIDTH      (WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .finish       (finish),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .ovf          (ovf),
        .trunc        (trunc)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        m_mant = 0; m_ndig = 0; m_nfrac = 0;
        m_pt = 0; m_neg = 0; m_trunc = 0;
    endfunction

    function automatic void model_key(input logic [3:0] k);
        if (k <= 4'd9) begin
            if (m_ndig < MAX_DIGITS) begin
                m_mant = m_mant * 10 + longint'(k);
                m_ndig++;
                if (m_pt) m_nfrac++;
            end else begin
                m_trunc = 1;
            end
        end else if (k == 4'hF) m_pt = 1;
        else if (k == 4'hE) m_neg = !m_neg;
        else if (k == 4'hC) model_clear();
    endfunction

    // value = floor(mant * 2^FRAC_BITS / 10^nfrac), clipped to the positive range, then signed.
    function automatic void model_expect(output logic [31:0] r, output bit o);
        longint p, q;
        p = 1;
        for (int i = 0; i < m_nfrac; i++) p = p * 10;
        q = (m_mant * (longint'(1) << FRAC_BITS)) / p;
        o = (q > 64'sd2147483647);
        if (o) q = 64'sd2147483647;
        if (m_neg) q = -q;
        r = q[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        model_key(k);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_result"}, result, 0);
        check_val({tag, "_valid"}, result_valid, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_ovf"}, ovf, 0);
        check_val({tag, "_trunc"}, trunc, 0);
    endtask

    // Raise finish (optionally with a final key in the same cycle) and check the
    // result pulse, its latency and the flags.
    task automatic convert(input string tag, input bit with_key, input logic [3:0] last_key,
                           input logic [31:0] exp_res, input bit exp_ovf, input bit exp_trunc);
        int lat;
        int busy_drop;
        lat = 0;
        busy_drop = 0;
        key_valid = with_key;
        key_code  = last_key;
        finish    = 1'b1;
        tick();
        key_valid = 1'b0;
        finish    = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (result_valid) begin
                lat = i;
                break;
            end
            if (!busy) busy_drop++;
        end
        check_val({tag, "_lat"}, lat, LAT);
        check_val({tag, "_result"}, result, exp_res);
        check_val({tag, "_ovf"}, ovf, exp_ovf);
        check_val({tag, "_trunc"}, trunc, exp_trunc);
        check_val({tag, "_busy_done"}, busy, 0);
        check_val({tag, "_busy_drop"}, busy_drop, 0);
        tick();
        check_val({tag, "_pulse"}, result_valid, 0);
        check_val({tag, "_hold"}, result, exp_res);
    endtask

    // Wait a bounded window and require that no result pulse appears.
    task automatic expect_no_result(input string tag, input logic [31:0] held, input bit exp_busy);
        int pulses;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (result_valid) pulses++;
        end
        check_val({tag, "_pulses"}, pulses, 0);
        check_val({tag, "_held"}, result, held);
        check_val({tag, "_busy"}, busy, exp_busy);
    endtask

    task automatic random_operand(input int idx);
        int n;
        int r;
        bit with_key;
        logic [3:0] k;
        logic [3:0] last;
        logic [31:0] er;
        bit eo;
        do_start();
        n = $urandom_range(0, 12);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 21);
            if (r <= 11) k = 4'(r % 10);
            else if (r <= 13) k = 4'hF;
            else if (r == 14) k = 4'hE;
            else if (r == 15) k = 4'hC;
            else if (r == 16) k = 4'hA;
            else if (r == 17) k = 4'hB;
            else if (r == 18) k = 4'hD;
            else k = 4'($urandom_range(0, 9));
            if (r == 21) begin
                key_valid = 1'b0;
                key_code  = k;
                tick();
            end else begin
                press(k);
            end
        end
        with_key = 1'($urandom_range(0, 1));
        last = 4'($urandom_range(0, 15));
        if (with_key) model_key(last);
        model_expect(er, eo);
        convert($sformatf("rnd%0d", idx), with_key, last, er, eo, m_trunc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        key_valid = 1'b0;
        key_code = 4'h0;
        finish = 1'b0;
        model_clear();
        tick();
        tick();
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // 24.59 -> 6295
        do_start();
        check_val("start_busy", busy, 1);
        press(4'd2); press(4'd4); press(4'hF); press(4'd5); press(4'd9);
        convert("dec_24_59", 1'b0, 4'h0, 32'h0000_1897, 1'b0, 1'b0);

        // -1.5 -> -384
        do_start();
        press(4'hE); press(4'd1); press(4'hF); press(4'd5);
        convert("neg_1_5", 1'b0, 4'h0, 32'hFFFF_FE80, 1'b0, 1'b0);

        // 99999999 saturates, both signs
        do_start();
        for (int i = 0; i < 8; i++) press(4'd9);
        convert("sat_pos", 1'b0, 4'h0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        do_start();
        press(4'hE);
        for (int i = 0; i < 8; i++) press(4'd9);
        convert("sat_neg", 1'b0, 4'h0, 32'h8000_0001, 1'b1, 1'b0);

        // nine digits: the ninth is dropped and trunc sticks
        do_start();
        for (int i = 1; i <= 8; i++) press(4'(i));
        check_val("trunc_before", trunc, 0);
        press(4'd9);
        check_val("trunc_live", trunc, 1);
        convert("nine_digits", 1'b0, 4'h0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // second point ignored: 1.25
        do_start();
        press(4'd1); press(4'hF); press(4'd2); press(4'hF); press(4'd5);
        convert("two_points", 1'b0, 4'h0, 32'h0000_0140, 1'b0, 1'b0);

        // keys and finish in IDLE do nothing
        press(4'd3);
        key_valid = 1'b1; key_code = 4'd4; finish = 1'b1;
        tick();
        key_valid = 1'b0; finish = 1'b0;
        expect_no_result("idle_keys", 32'h0000_0140, 1'b0);

        // abort a conversion 10 cycles into DIVIDE
        do_start();
        press(4'd3); press(4'hF); press(4'd2);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check_val("abort_busy_div", busy, 1);
        do_start();
        expect_no_result("abort", 32'h0000_0140, 1'b1);
        press(4'd7);
        convert("after_abort", 1'b0, 4'h0, 32'h0000_0700, 1'b0, 1'b0);

        // clear entry, including trunc; zero digits with sign gives 0
        do_start();
        for (int i = 1; i <= 9; i++) press(4'(i));
        press(4'hC);
        check_val("clear_trunc", trunc, 0);
        press(4'd2);
        convert("after_clear", 1'b0, 4'h0, 32'h0000_0200, 1'b0, 1'b0);
        do_start();
        press(4'hE);
        convert("zero_neg", 1'b0, 4'h0, 32'h0000_0000, 1'b0, 1'b0);

        // key in the same cycle as finish is taken: 3 then 5 -> 35
        do_start();
        press(4'd3);
        convert("key_with_finish", 1'b1, 4'd5, 32'h0000_2300, 1'b0, 1'b0);

        // reset mid-ENTRY with ovf and trunc set
        do_start();
        for (int i = 0; i < 8; i++) press(4'd9);
        convert("pre_rst1", 1'b0, 4'h0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        do_start();
        for (int i = 1; i <= 9; i++) press(4'(i));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outputs_zero("rst_entry");
        press(4'd4);
        key_valid = 1'b1; key_code = 4'd1; finish = 1'b1;
        tick();
        key_valid = 1'b0; finish = 1'b0;
        expect_no_result("rst_entry_idle", 32'h0, 1'b0);

        // reset mid-DIVIDE
        do_start();
        for (int i = 0; i < 8; i++) press(4'd9);
        convert("pre_rst2", 1'b0, 4'h0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        do_start();
        press(4'd5);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_outputs_zero("rst_div");
        expect_no_result("rst_div_idle", 32'h0, 1'b0);

        for (int t = 0; t < 30; t++) random_operand(t);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
